// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds one byte at a time from four requesters to a single
// UART transmitter, with a per-byte completion timeout.
module uart_tx_arbiter #(
    parameter int clk_freq   = 1000000,
    parameter int baud_rate  = 9600,
    parameter int tx_timeout = 2 * 10 * clk_freq / baud_rate
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [31:0] din,
    output logic [3:0]  gnt,
    output logic [3:0]  done,
    output logic        newd,
    output logic [7:0]  dintx,
    input  logic        donetx,
    output logic        busy,
    output logic        err,
    output logic [1:0]  err_id
);
    localparam int cnt_w = $clog2(tx_timeout + 1);
    localparam logic [cnt_w-1:0] timeout_c = cnt_w'(tx_timeout);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t           state_r, next_state_s;
    logic [1:0]       ptr_r, ptr_s;
    logic [1:0]       gidx_r, gidx_s;
    logic [3:0]       gnt_r, gnt_s;
    logic [3:0]       done_r, done_s;
    logic             newd_r, newd_s;
    logic [7:0]       dintx_r, dintx_s;
    logic             busy_r, busy_s;
    logic             err_r, err_s;
    logic [1:0]       err_id_r, err_id_s;
    logic [cnt_w-1:0] cnt_r, cnt_s;
    logic             pick_vld_s;
    logic [1:0]       pick_idx_s;

    // First asserted requester at or after p, wrapping mod 4; result is {valid, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] cand;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            cand = p + 2'(i);
            if (r[cand]) begin
                res = {1'b1, cand};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Arbitration candidate for the current pointer.
    always_comb begin
        {pick_vld_s, pick_idx_s} = rr_pick(req, ptr_r);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a completion on the timeout cycle wins over the timeout.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE:   next_state_s = pick_vld_s ? ST_LAUNCH : ST_IDLE;
            ST_LAUNCH: next_state_s = ST_WAIT;
            ST_WAIT: begin
                if (donetx) begin
                    next_state_s = ST_DONE;
                end else if (cnt_r == timeout_c) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_DONE:   next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        ptr_s    = ptr_r;
        gidx_s   = gidx_r;
        gnt_s    = gnt_r;
        done_s   = 4'b0000;
        newd_s   = 1'b0;
        dintx_s  = dintx_r;
        err_s    = 1'b0;
        err_id_s = err_id_r;
        cnt_s    = cnt_r;
        busy_s   = (next_state_s != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                if (pick_vld_s) begin
                    gidx_s  = pick_idx_s;
                    gnt_s   = 4'b0001 << pick_idx_s;
                    dintx_s = din[{pick_idx_s, 3'b000} +: 8];
                end else begin
                    gnt_s = 4'b0000;
                end
            end
            ST_LAUNCH: begin
                newd_s = 1'b1;
                cnt_s  = '0;
            end
            ST_WAIT: begin
                if (donetx) begin
                    done_s = gnt_r;
                end else if (cnt_r == timeout_c) begin
                    err_s    = 1'b1;
                    err_id_s = gidx_r;
                    gnt_s    = 4'b0000;
                    ptr_s    = gidx_r + 2'd1;
                end else begin
                    cnt_s = cnt_r + cnt_w'(1);
                end
            end
            ST_DONE: begin
                gnt_s = 4'b0000;
                ptr_s = gidx_r + 2'd1;
            end
            default: begin
                gnt_s = 4'b0000;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r    <= 2'd0;
            gidx_r   <= 2'd0;
            gnt_r    <= 4'b0000;
            done_r   <= 4'b0000;
            newd_r   <= 1'b0;
            dintx_r  <= 8'h00;
            busy_r   <= 1'b0;
            err_r    <= 1'b0;
            err_id_r <= 2'd0;
            cnt_r    <= '0;
        end else begin
            ptr_r    <= ptr_s;
            gidx_r   <= gidx_s;
            gnt_r    <= gnt_s;
            done_r   <= done_s;
            newd_r   <= newd_s;
            dintx_r  <= dintx_s;
            busy_r   <= busy_s;
            err_r    <= err_s;
            err_id_r <= err_id_s;
            cnt_r    <= cnt_s;
        end
    end

    assign gnt    = gnt_r;
    assign done   = done_r;
    assign newd   = newd_r;
    assign dintx  = dintx_r;
    assign busy   = busy_r;
    assign err    = err_r;
    assign err_id = err_id_r;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: expected (requester, byte) pairs are queued
// when requests are driven and matched against each newd launch.
module tb_uart_tx_arbiter;
    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] din;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        newd;
    logic [7:0]  dintx;
    logic        donetx;
    logic        busy;
    logic        err;
    logic [1:0]  err_id;

    typedef struct {
        logic [1:0] idx;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   failures;

    uart_tx_arbiter #(.clk_freq(1000000), .baud_rate(9600), .tx_timeout(20)) dut (
        .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt), .done(done),
        .newd(newd), .dintx(dintx), .donetx(donetx), .busy(busy), .err(err), .err_id(err_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        req = 4'b0000;
        donetx = 1'b0;
        sb.delete();
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic wait_newd(output int n);
        n = 0;
        while (newd !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
    endtask

    // Serve one launched byte: check launch against the scoreboard, then complete it.
    task automatic do_byte(input int delay);
        int   n;
        exp_t e;
        logic [3:0] oh;
        wait_newd(n);
        checks++;
        if (newd !== 1'b1) begin
            failures++;
            $display("FAIL newd_timeout: newd=%b after %0d cycles, required 1", newd, n);
        end
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_empty: launch with gnt=%b dintx=%h but nothing expected", gnt, dintx);
            e.idx = 2'd0;
            e.data = 8'h00;
        end else begin
            e = sb.pop_front();
        end
        oh = 4'b0001 << e.idx;
        checks++;
        if (gnt !== oh) begin
            failures++;
            $display("FAIL launch_gnt: gnt=%b, required %b", gnt, oh);
        end
        checks++;
        if (dintx !== e.data) begin
            failures++;
            $display("FAIL launch_dintx: dintx=%h, required %h", dintx, e.data);
        end
        tick();
        checks++;
        if (newd !== 1'b0) begin
            failures++;
            $display("FAIL newd_width: newd=%b one cycle later, required 0", newd);
        end
        repeat (delay) tick();
        donetx = 1'b1;
        tick();
        donetx = 1'b0;
        checks++;
        if (done !== oh || err !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse: done=%b err=%b, required done=%b err=0", done, err, oh);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = 4'b0000;
        din = 32'h0;
        donetx = 1'b0;
        #3;
        checks++;
        if ({gnt, done, newd, dintx, busy, err, err_id} !== 21'h0) begin
            failures++;
            $display("FAIL reset_outputs: gnt=%b done=%b newd=%b dintx=%h busy=%b err=%b err_id=%0d, required all 0",
                     gnt, done, newd, dintx, busy, err, err_id);
        end
        apply_reset();
    endtask

    task automatic test_single();
        apply_reset();
        din = 32'h000000A5;
        req = 4'b0001;
        sb.push_back('{2'd0, 8'hA5});
        tick();
        checks++;
        if (gnt !== 4'b0001 || newd !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_grant: gnt=%b newd=%b busy=%b, required 0001/0/1", gnt, newd, busy);
        end
        tick();
        checks++;
        if (newd !== 1'b1) begin
            failures++;
            $display("FAIL single_latency: newd=%b two cycles after req, required 1", newd);
        end
        do_byte(48);
        req = 4'b0000;
        tick();
        checks++;
        if (done !== 4'b0000 || gnt !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_exit: done=%b gnt=%b busy=%b, required 0000/0000/0", done, gnt, busy);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        din = 32'h44332211;
        req = 4'b1111;
        sb.push_back('{2'd0, 8'h11});
        sb.push_back('{2'd1, 8'h22});
        sb.push_back('{2'd2, 8'h33});
        sb.push_back('{2'd3, 8'h44});
        sb.push_back('{2'd0, 8'h11});
        for (int k = 0; k < 5; k++) begin
            do_byte(3);
        end
        req = 4'b0000;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL rr_drain: busy=%b pending=%0d, required 0/0", busy, sb.size());
        end
    endtask

    task automatic test_timeout();
        int n;
        bit saw_done;
        apply_reset();
        din = 32'h445C2211;
        req = 4'b0100;
        wait_newd(n);
        checks++;
        if (newd !== 1'b1 || gnt !== 4'b0100) begin
            failures++;
            $display("FAIL to_launch: newd=%b gnt=%b, required 1/0100", newd, gnt);
        end
        n = 0;
        saw_done = 1'b0;
        while (err !== 1'b1 && n < 40) begin
            tick();
            n++;
            if (done !== 4'b0000) saw_done = 1'b1;
        end
        checks++;
        if (err !== 1'b1 || n != 21) begin
            failures++;
            $display("FAIL to_latency: err=%b after %0d cycles, required 1 after 21", err, n);
        end
        checks++;
        if (err_id !== 2'd2 || gnt !== 4'b0000 || busy !== 1'b0 || saw_done) begin
            failures++;
            $display("FAIL to_state: err_id=%0d gnt=%b busy=%b saw_done=%b, required 2/0000/0/0",
                     err_id, gnt, busy, saw_done);
        end
        req = 4'b1111;
        sb.push_back('{2'd3, 8'h44});
        tick();
        checks++;
        if (err !== 1'b0 || err_id !== 2'd2) begin
            failures++;
            $display("FAIL to_hold: err=%b err_id=%0d, required 0/2", err, err_id);
        end
        do_byte(2);
        req = 4'b0000;
        tick();
    endtask

    task automatic test_timeout_tie();
        apply_reset();
        din = 32'h0000007E;
        req = 4'b0001;
        sb.push_back('{2'd0, 8'h7E});
        do_byte(19);
        req = 4'b0000;
        tick();
        checks++;
        if (err !== 1'b0 || err_id !== 2'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL tie_no_err: err=%b err_id=%0d busy=%b, required 0/0/0", err, err_id, busy);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        apply_reset();
        din = 32'h0000BB99;
        req = 4'b0010;
        wait_newd(n);
        repeat (4) tick();
        checks++;
        if (busy !== 1'b1 || gnt !== 4'b0010) begin
            failures++;
            $display("FAIL mid_pre: busy=%b gnt=%b, required 1/0010", busy, gnt);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({gnt, done, newd, dintx, busy, err, err_id} !== 21'h0) begin
            failures++;
            $display("FAIL mid_reset: gnt=%b done=%b newd=%b dintx=%h busy=%b err=%b err_id=%0d, required all 0",
                     gnt, done, newd, dintx, busy, err, err_id);
        end
        req = 4'b0011;
        tick();
        rst = 1'b1;
        sb.push_back('{2'd0, 8'h99});
        do_byte(1);
        req = 4'b0000;
        tick();
    endtask

    task automatic test_spurious();
        apply_reset();
        din = 32'h0000003C;
        donetx = 1'b1;
        repeat (3) tick();
        donetx = 1'b0;
        checks++;
        if (busy !== 1'b0 || gnt !== 4'b0000 || done !== 4'b0000 || err !== 1'b0) begin
            failures++;
            $display("FAIL idle_donetx: busy=%b gnt=%b done=%b err=%b, required 0", busy, gnt, done, err);
        end
        req = 4'b0001;
        sb.push_back('{2'd0, 8'h3C});
        tick();
        din = 32'hFFFFFFFF;
        donetx = 1'b1;
        tick();
        donetx = 1'b0;
        checks++;
        if (newd !== 1'b1 || done !== 4'b0000) begin
            failures++;
            $display("FAIL launch_donetx: newd=%b done=%b, required 1/0000", newd, done);
        end
        do_byte(5);
        req = 4'b0000;
        tick();
        checks++;
        if (dintx !== 8'h3C) begin
            failures++;
            $display("FAIL dintx_hold: dintx=%h, required 3c", dintx);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_timeout_tie();
        test_reset_mid();
        test_spurious();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter clk_freq, default 1000000, meaning system clock frequency in Hz (informational; sizes the default timeout).
REQ-002 The block SHALL have parameter baud_rate, default 9600, meaning UART line rate.
REQ-003 The block SHALL have parameter tx_timeout, default 2*10*clk_freq/baud_rate, meaning the maximum WAIT cycles before a byte is abandoned.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-006 Port: rst  input  1  asynchronous active-low reset.
REQ-007 Port: req  input  4  per-requester transmit request, level, held until its done pulse.
REQ-008 Port: din  input  32  requester data; byte i = din[8i+7:8i].
REQ-009 Port: gnt  output  4  one-hot grant, held LAUNCH through DONE.
REQ-010 Port: done  output  4  one-cycle pulse to requester i when its byte is sent.
REQ-011 Port: newd  output  1  one-cycle start pulse to the UART transmitter.
REQ-012 Port: dintx  output  8  byte to the UART transmitter, registered.
REQ-013 Port: donetx  input  1  UART transmitter completion pulse.
REQ-014 Port: busy  output  1  high whenever state is not IDLE.
REQ-015 Port: err  output  1  one-cycle pulse on timeout.
REQ-016 Port: err_id  output  2  index of timed-out requester, valid with err, held until next err.

Function
REQ-017 The FSM SHALL have states IDLE, LAUNCH, WAIT, DONE.
REQ-018 In IDLE with req!=0, the next edge SHALL select the first asserted requester searching ptr, ptr+1, ... mod 4, load gnt one-hot, load dintx with that byte, and enter LAUNCH.
REQ-019 In LAUNCH, newd SHALL be 1 for exactly that one cycle; next state WAIT, timeout counter cleared to 0.
REQ-020 In WAIT, the counter SHALL increment each cycle; donetx=1 SHALL move to DONE.
REQ-021 In WAIT, counter == tx_timeout with donetx=0 SHALL pulse err, load err_id, clear gnt, set ptr = granted+1 mod 4, and enter IDLE with no done pulse.
REQ-022 donetx and timeout in the same cycle SHALL be treated as donetx (no err).
REQ-023 In DONE, done[granted] SHALL pulse for one cycle, ptr SHALL become granted+1 mod 4, gnt SHALL clear on exit, next state IDLE.
REQ-024 Grant-to-newd latency SHALL be 1 cycle; req to newd SHALL be 2 cycles from IDLE.
REQ-025 After DONE, a pending request SHALL be granted on the following IDLE cycle (minimum 4 cycles per byte excluding the UART frame).
REQ-026 din SHALL be sampled only at the grant edge; later din changes SHALL not affect dintx.
REQ-027 Deassertion of req[granted] after grant SHALL NOT abort the transfer.
REQ-028 donetx outside WAIT SHALL be ignored.
REQ-029 Counter width SHALL be $clog2(tx_timeout+1) bits; it SHALL not wrap within WAIT.
REQ-030 gnt, done, err SHALL each be one-hot or zero at all times.

Reset
REQ-031 On rst=0, asynchronously: state IDLE, ptr=0, gnt=0, done=0, newd=0, dintx=0x00, busy=0, err=0, err_id=0, counter=0.
REQ-032 Reset mid-transfer SHALL abandon the byte with no done or err pulse.
REQ-033 The first grant after reset SHALL favour requester 0.

Verification
REQ-034 req=4'b0001, din[7:0]=0xA5, donetx after 50 cycles -> gnt=0001, newd pulse with dintx=0xA5 2 cycles after req, done=0001 one cycle after donetx.
REQ-035 req=4'b1111 held, bytes 0x11/0x22/0x33/0x44 -> service order 0,1,2,3,0, each with one newd; no requester granted twice before others.
REQ-036 tx_timeout=20, req=4'b0100, donetx never -> err pulse 21 cycles after LAUNCH, err_id=2, no done, ptr=3.
REQ-037 donetx asserted on exactly the timeout cycle -> done pulse, err stays 0.
REQ-038 rst low during WAIT for requester 1 -> all outputs zero immediately; after release req=4'b0011 -> requester 0 granted first.
REQ-039 Spurious donetx in IDLE, din changed after grant -> no state change; dintx keeps grant-time byte.
